// File: rtl/cdec8_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdec8_dump_pkg
// Brief    : Shared widths and dump-reader state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package cdec8_dump_pkg;

    localparam int ADRS_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SHOW    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_dump_reader_if
// Brief    : Control, RAM read and display signals of the dump reader.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_dump_reader_if #(
    parameter int ADRS_W = cdec8_dump_pkg::ADRS_W_DEF,
    parameter int DATA_W = cdec8_dump_pkg::DATA_W_DEF
);
    logic              start;
    logic              step;
    logic              auto_en;
    logic              abort;
    logic [ADRS_W-1:0] start_adrs;
    logic [ADRS_W-1:0] end_adrs;
    logic [DATA_W-1:0] mm_q;
    logic [ADRS_W-1:0] rd_adrs;
    logic [ADRS_W-1:0] dump_adrs;
    logic [DATA_W-1:0] dump_data;
    logic              dump_valid;
    logic [DATA_W-1:0] checksum;
    logic              busy;
    logic              done;

    modport master (
        input  start, step, auto_en, abort, start_adrs, end_adrs, mm_q,
        output rd_adrs, dump_adrs, dump_data, dump_valid, checksum, busy, done
    );

    modport slave (
        output start, step, auto_en, abort, start_adrs, end_adrs, mm_q,
        input  rd_adrs, dump_adrs, dump_data, dump_valid, checksum, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/rise_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : rise_edge_det
// Brief    : Two-flop rising-edge detector; one-cycle pulse per 0->1 of din.
// Revision : 1.0 - initial release
// ============================================================================
module rise_edge_det (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise
);
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        sync_d = din;
        prev_d = sync_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q & ~prev_q;
endmodule
`default_nettype wire

// File: rtl/mem_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : mem_dump_reader
// Brief    : Walks RAM over an address range, shows each word, sums a checksum.
// Revision : 1.0 - initial release
// ============================================================================
module mem_dump_reader
    import cdec8_dump_pkg::*;
#(
    parameter int ADRS_W   = ADRS_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = 1,
    parameter int AUTO_DIV = 5000000
)(
    input  logic              clock,
    input  logic              reset,
    mem_dump_reader_if.master bus
);
    localparam int         TICK_W    = $clog2(AUTO_DIV);
    localparam logic [1:0] WAIT_INIT = 2'(READ_LAT - 1);

    state_t            state_q, state_d;
    logic [ADRS_W-1:0] cur_q, cur_d;
    logic [ADRS_W-1:0] last_q, last_d;
    logic [ADRS_W-1:0] rd_adrs_q, rd_adrs_d;
    logic [ADRS_W-1:0] dump_adrs_q, dump_adrs_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic [1:0]        wait_q, wait_d;
    logic [TICK_W-1:0] tick_q, tick_d;

    logic start_rise;
    logic step_rise;
    logic tick_hit;
    logic advance;

    rise_edge_det u_start_edge (
        .clock (clock),
        .reset (reset),
        .din   (bus.start),
        .rise  (start_rise)
    );

    rise_edge_det u_step_edge (
        .clock (clock),
        .reset (reset),
        .din   (bus.step),
        .rise  (step_rise)
    );

    assign tick_hit = (tick_q == TICK_W'(AUTO_DIV - 1));
    assign advance  = (state_q == ST_SHOW) && (bus.auto_en ? tick_hit : step_rise);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (start_rise) state_d = ST_ISSUE;
                ST_ISSUE:         state_d = ST_WAIT;
                ST_WAIT:          if (wait_q == 2'd0) state_d = ST_CAPTURE;
                ST_CAPTURE:       state_d = ST_SHOW;
                ST_SHOW:          if (advance) state_d = (cur_q == last_q) ? ST_DONE : ST_ISSUE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    // Tick counter defaults to zero, so it restarts on SHOW entry and whenever auto_en drops.
    always_comb begin
        cur_d       = cur_q;
        last_d      = last_q;
        rd_adrs_d   = rd_adrs_q;
        dump_adrs_d = dump_adrs_q;
        dump_data_d = dump_data_q;
        checksum_d  = checksum_q;
        wait_d      = wait_q;
        tick_d      = '0;
        if (!bus.abort) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_rise) begin
                        cur_d      = bus.start_adrs;
                        last_d     = bus.end_adrs;
                        checksum_d = '0;
                    end
                end
                ST_ISSUE: begin
                    rd_adrs_d = cur_q;
                    wait_d    = WAIT_INIT;
                end
                ST_WAIT: begin
                    if (wait_q != 2'd0) wait_d = wait_q - 2'd1;
                end
                ST_CAPTURE: begin
                    dump_adrs_d = cur_q;
                    dump_data_d = bus.mm_q;
                    checksum_d  = checksum_q + bus.mm_q;
                end
                ST_SHOW: begin
                    if (advance) begin
                        if (cur_q != last_q) cur_d = cur_q + 1'b1;
                    end else if (bus.auto_en) begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_q       <= '0;
            last_q      <= '0;
            rd_adrs_q   <= '0;
            dump_adrs_q <= '0;
            dump_data_q <= '0;
            checksum_q  <= '0;
            wait_q      <= '0;
            tick_q      <= '0;
        end else begin
            cur_q       <= cur_d;
            last_q      <= last_d;
            rd_adrs_q   <= rd_adrs_d;
            dump_adrs_q <= dump_adrs_d;
            dump_data_q <= dump_data_d;
            checksum_q  <= checksum_d;
            wait_q      <= wait_d;
            tick_q      <= tick_d;
        end
    end

    always_comb begin
        bus.dump_valid = (state_q == ST_CAPTURE) && !bus.abort;
        bus.busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
        bus.done       = (state_q == ST_DONE);
    end

    assign bus.rd_adrs   = rd_adrs_q;
    assign bus.dump_adrs = dump_adrs_q;
    assign bus.dump_data = dump_data_q;
    assign bus.checksum  = checksum_q;
endmodule
`default_nettype wire
